ldm_stm_seq: RTL

Load/store-multiple sequencer for the ARM-style core. It sits between the decode stage, the banked register file and the data-memory port. It walks a 16-bit register list and, for each selected register, issues one word memory request. For stores it sources data through a register-file read port; for loads it drives the register-file write port and `write_pc`. It optionally writes the updated base back to Rn.

---
 rtl/ldm_stm_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ldm_stm_seq.sv
// Load/store-multiple sequencer: walks a 16-bit register list and issues one
// word memory request per selected register, lowest register first at the
// lowest address. Loads write the register file (or the PC for r15); stores
// read their data through the register-file read port. The updated base can
// optionally be written back to Rn after the last transfer.
module ldm_stm_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        pre,
    input  logic        up,
    input  logic        wback,
    input  logic [3:0]  rn,
    input  logic [31:0] base,
    input  logic [15:0] reg_list,
    output logic [3:0]  r_addr,
    input  logic [31:0] r_data,
    output logic [3:0]  w_addr,
    output logic [31:0] w_data,
    output logic        write_reg,
    output logic        write_pc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        is_load_q, is_load_d;
    logic        wb_en_q, wb_en_d;      // writeback requested and not overridden by a load of Rn
    logic [3:0]  rn_q, rn_d;
    logic [15:0] list_q, list_d;        // registers still to be transferred
    logic [31:0] addr_q, addr_d;        // address of the current transfer
    logic [31:0] final_q, final_d;      // base value written back in WB

    logic [4:0]  cnt;
    logic [31:0] base_al;
    logic [31:0] span;
    logic [31:0] start_addr;
    logic [31:0] final_addr;
    logic [3:0]  cur;
    logic        last;

    // Number of registers in the incoming list.
    // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'b0, reg_list[i]};
        end
    end

    // First transfer address and final base from the P/U bits; base is word-aligned.
    always_comb begin
        base_al    = {base[31:2], 2'b00};
        span       = {25'b0, cnt, 2'b00};
        final_addr = up ? (base_al + span) : (base_al - span);
        unique case ({pre, up})
            2'b01:   start_addr = base_al;                  // IA
            2'b11:   start_addr = base_al + 32'd4;          // IB
            2'b00:   start_addr = base_al - span + 32'd4;   // DA
            default: start_addr = base_al - span;           // DB
        endcase
    end

    // Current register is the lowest set bit still pending.
    always_comb begin
        cur = '0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) cur = 4'(i);
        end
        last = (list_q & (list_q - 16'd1)) == 16'd0;
    end

    // Next-state logic and command capture.
    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        wb_en_d   = wb_en_q;
        rn_d      = rn_q;
        list_d    = list_q;
        addr_d    = addr_q;
        final_d   = final_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_load_d = is_load;
                    wb_en_d   = wback && !(is_load && reg_list[rn]);
                    rn_d      = rn;
                    list_d    = reg_list;
                    addr_d    = start_addr;
                    final_d   = final_addr;
                    state_d   = (reg_list == 16'd0) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (mem_ready) begin
                    list_d = list_q & (list_q - 16'd1);
                    addr_d = addr_q + 32'd4;
                    if (last) state_d = wb_en_q ? S_WB : S_DONE;
                end
            end
            S_WB:    state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory, register-file and status outputs decoded from the current state.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        r_addr    = '0;
        write_reg = 1'b0;
        write_pc  = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        unique case (state_q)
            S_XFER: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (!is_load_q) begin
                    mem_we    = 1'b1;
                    r_addr    = cur;
                    mem_wdata = r_data;
                end else if (mem_ready) begin
                    w_data = mem_rdata;
                    if (cur == 4'd15) begin
                        write_pc = 1'b1;
                    end else begin
                        write_reg = 1'b1;
                        w_addr    = cur;
                    end
                end
            end
            S_WB: begin
                write_reg = 1'b1;
                w_addr    = rn_q;
                w_data    = final_q;
            end
            default: ;
        endcase
    end

    // State register; reset abandons any in-flight sequence.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            is_load_q <= 1'b0;
            wb_en_q   <= 1'b0;
            rn_q      <= '0;
            list_q    <= '0;
            addr_q    <= '0;
            final_q   <= '0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            wb_en_q   <= wb_en_d;
            rn_q      <= rn_d;
            list_q    <= list_d;
            addr_q    <= addr_d;
            final_q   <= final_d;
        end
    end

endmodule
